// File: rtl/frame_read_addr_gen.sv
// Frame read address generator: walks a 2-D frame line by line and issues
// burst read requests (address, pixel count) to a read engine via kick/busy.
module frame_read_addr_gen #(
    parameter int ADDR_W    = 32,
    parameter int BPP       = 4,
    parameter int BURST_PIX = 64,
    parameter int DIM_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [DIM_W-1:0]  x_size,
    input  logic [DIM_W-1:0]  y_size,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic [31:0]       fifo_available,
    input  logic [31:0]       fifo_threshold,
    input  logic              busy,
    output logic              kick,
    output logic [ADDR_W-1:0] read_addr,
    output logic [DIM_W-1:0]  read_num,
    output logic              active,
    output logic              frame_done
);

    localparam int BPP_SH = $clog2(BPP);
    localparam int CNT_W  = DIM_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_IDLE,
        ISSUE,
        ISSUE_WAIT,
        NEXT_LINE
    } state_t;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    x_size_q, x_size_d;
    logic [DIM_W-1:0]    y_size_q, y_size_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [CNT_W-1:0]    x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]    y_cnt_q, y_cnt_d;
    logic                abort_q, abort_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DIM_W-1:0]    num_q, num_d;

    logic [CNT_W-1:0]    remain;
    logic [CNT_W-1:0]    burst_num;
    logic [ADDR_W-1:0]   burst_addr;

    // line_addr_q tracks base + y_cnt*stride incrementally, so only the
    // in-line pixel offset is added per burst; both wrap modulo 2^ADDR_W.
    always_comb begin
        remain     = {1'b0, x_size_q} - x_cnt_q;
        burst_num  = (remain > CNT_W'(BURST_PIX)) ? CNT_W'(BURST_PIX) : remain;
        burst_addr = line_addr_q + (ADDR_W'(x_cnt_q) << BPP_SH);
    end

    always_comb begin
        state_d     = state_q;
        x_size_d    = x_size_q;
        y_size_d    = y_size_q;
        stride_d    = stride_q;
        line_addr_d = line_addr_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        abort_d     = abort_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        num_d       = num_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((x_size != '0) && (y_size != '0)) begin
                        x_size_d    = x_size;
                        y_size_d    = y_size;
                        stride_d    = line_stride;
                        line_addr_d = frame_base;
                        x_cnt_d     = '0;
                        y_cnt_d     = '0;
                        abort_d     = 1'b0;
                        state_d     = ISSUE_IDLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE_IDLE: begin
                if (abort) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!busy) begin
                    addr_d  = burst_addr;
                    num_d   = DIM_W'(burst_num);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                x_cnt_d = x_cnt_q + CNT_W'(num_q);
                if (abort) begin
                    abort_d = 1'b1;
                end
                state_d = ISSUE_WAIT;
            end
            ISSUE_WAIT: begin
                // A pending abort is only acted on once the engine accepts
                // the outstanding request, so the handshake is never torn.
                if (busy) begin
                    if (abort_q || abort) begin
                        abort_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (x_cnt_q == {1'b0, x_size_q}) begin
                        x_cnt_d     = '0;
                        y_cnt_d     = y_cnt_q + CNT_W'(1);
                        line_addr_d = line_addr_q + stride_q;
                        state_d     = NEXT_LINE;
                    end else begin
                        state_d = ISSUE_IDLE;
                    end
                end else if (abort) begin
                    abort_d = 1'b1;
                end
            end
            NEXT_LINE: begin
                if (abort || (y_cnt_q == {1'b0, y_size_q})) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (fifo_available < fifo_threshold) begin
                    state_d = ISSUE_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_size_q    <= '0;
            y_size_q    <= '0;
            stride_q    <= '0;
            line_addr_q <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            num_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_size_q    <= x_size_d;
            y_size_q    <= y_size_d;
            stride_q    <= stride_d;
            line_addr_q <= line_addr_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
        end
    end

    assign kick       = (state_q == ISSUE) || (state_q == ISSUE_WAIT);
    assign active     = (state_q != IDLE);
    assign frame_done = done_q;
    assign read_addr  = addr_q;
    assign read_num   = num_q;

endmodule

// File: tb/tb_frame_read_addr_gen.sv
// Directed bench for frame_read_addr_gen: table of frame configurations with
// hand-computed request lists, plus sequences for busy/fifo/abort/reset cases.
module tb_frame_read_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] frame_base = '0;
    logic [11:0] x_size = '0;
    logic [11:0] y_size = '0;
    logic [31:0] line_stride = '0;
    logic [31:0] fifo_available = '0;
    logic [31:0] fifo_threshold = 32'd1600;
    logic        busy;
    logic        busy_man = 1'b0;
    logic        busy_auto = 1'b0;
    logic        auto_busy = 1'b0;
    logic        kick;
    logic [31:0] read_addr;
    logic [11:0] read_num;
    logic        active;
    logic        frame_done;

    assign busy = auto_busy ? busy_auto : busy_man;

    frame_read_addr_gen #(
        .ADDR_W(32), .BPP(4), .BURST_PIX(64), .DIM_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .frame_base(frame_base), .x_size(x_size), .y_size(y_size),
        .line_stride(line_stride), .fifo_available(fifo_available),
        .fifo_threshold(fifo_threshold), .busy(busy), .kick(kick),
        .read_addr(read_addr), .read_num(read_num), .active(active),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Read-engine model: raise busy two cycles after kick, hold it three cycles.
    int kc = 0;
    int bcnt = 0;
    always @(posedge clk) begin
        #1;
        if (!auto_busy || !rst_n) begin
            busy_auto = 1'b0; kc = 0; bcnt = 0;
        end else if (busy_auto) begin
            if (bcnt == 0) busy_auto = 1'b0;
            else bcnt--;
        end else if (kick) begin
            kc++;
            if (kc >= 2) begin busy_auto = 1'b1; bcnt = 2; kc = 0; end
        end else begin
            kc = 0;
        end
    end

    // Request / frame_done monitor, sampled on the falling edge.
    logic [31:0] mon_addr [0:511];
    logic [11:0] mon_num  [0:511];
    int          req_n = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    logic        kick_prev = 1'b0;
    logic [31:0] held_a = '0;
    logic [11:0] held_n = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            kick_prev = 1'b0;
        end else begin
            if (kick && !kick_prev) begin
                if (req_n < 512) begin
                    mon_addr[req_n] = read_addr;
                    mon_num[req_n]  = read_num;
                end
                req_n++;
                held_a = read_addr;
                held_n = read_num;
            end else if (kick && ((read_addr !== held_a) || (read_num !== held_n))) begin
                stab_err++;
            end
            if (frame_done) done_cnt++;
            kick_prev = kick;
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [11:0] x, input logic [11:0] y,
                               input logic [31:0] s);
        step();
        frame_base = b; x_size = x; y_size = y; line_stride = s; start = 1'b1;
        step();
        start = 1'b0;
        frame_base = 32'hDEAD_0000; x_size = 12'd7; y_size = 12'd9; line_stride = 32'h4;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int k = 0;
        while ((done_cnt == d0) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk(name, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_kick(input int budget, input string name);
        int k = 0;
        while (!kick && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(kick), 32'd1);
    endtask

    typedef struct packed {
        logic [31:0]       base;
        logic [11:0]       x;
        logic [11:0]       y;
        logic [31:0]       stride;
        logic [15:0]       n;
        logic [3:0][31:0]  ea;
        logic [3:0][11:0]  en;
        logic [31:0]       la;
        logic [11:0]       ln;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] b, input logic [11:0] x, input logic [11:0] y,
                                input logic [31:0] s, input logic [15:0] n,
                                input logic [31:0] a0, input logic [11:0] n0,
                                input logic [31:0] a1, input logic [11:0] n1,
                                input logic [31:0] a2, input logic [11:0] n2,
                                input logic [31:0] a3, input logic [11:0] n3,
                                input logic [31:0] la, input logic [11:0] ln);
        vec_t v;
        v.base = b; v.x = x; v.y = y; v.stride = s; v.n = n;
        v.ea[0] = a0; v.en[0] = n0; v.ea[1] = a1; v.en[1] = n1;
        v.ea[2] = a2; v.en[2] = n2; v.ea[3] = a3; v.en[3] = n3;
        v.la = la; v.ln = ln;
        return v;
    endfunction

    task automatic run_row(input int r, input vec_t v);
        int n0 = req_n;
        int d0 = done_cnt;
        int s0 = stab_err;
        string tag;
        start_frame(v.base, v.x, v.y, v.stride);
        wait_done(d0, 3000, $sformatf("row%0d_done", r));
        chk($sformatf("row%0d_count", r), 32'(req_n - n0), 32'(v.n));
        for (int i = 0; (i < 4) && (i < int'(v.n)); i++) begin
            tag = $sformatf("row%0d_req%0d", r, i);
            chk({tag, "_addr"}, mon_addr[n0 + i], v.ea[i]);
            chk({tag, "_num"}, 32'(mon_num[n0 + i]), 32'(v.en[i]));
        end
        chk($sformatf("row%0d_last_addr", r), mon_addr[n0 + int'(v.n) - 1], v.la);
        chk($sformatf("row%0d_last_num", r), 32'(mon_num[n0 + int'(v.n) - 1]), 32'(v.ln));
        chk($sformatf("row%0d_stable", r), 32'(stab_err - s0), 32'd0);
        chk($sformatf("row%0d_idle", r), 32'(active), 32'd0);
    endtask

    vec_t tbl [6];

    initial begin
        int n0, d0, s0, hk;

        tbl[0] = mk(32'h1000, 12'd100, 12'd2, 32'd512, 16'd4,
                    32'h1000, 12'd64, 32'h1100, 12'd36, 32'h1200, 12'd64, 32'h1300, 12'd36,
                    32'h1300, 12'd36);
        tbl[1] = mk(32'h2000, 12'd128, 12'd1, 32'h400, 16'd2,
                    32'h2000, 12'd64, 32'h2100, 12'd64, 32'h0, 12'd0, 32'h0, 12'd0,
                    32'h2100, 12'd64);
        tbl[2] = mk(32'h0, 12'd1, 12'd3, 32'd16, 16'd3,
                    32'h0, 12'd1, 32'h10, 12'd1, 32'h20, 12'd1, 32'h0, 12'd0,
                    32'h20, 12'd1);
        tbl[3] = mk(32'hFFFF_FF00, 12'd70, 12'd2, 32'h100, 16'd4,
                    32'hFFFF_FF00, 12'd64, 32'h0, 12'd6, 32'h0, 12'd64, 32'h100, 12'd6,
                    32'h100, 12'd6);
        tbl[4] = mk(32'h40, 12'd64, 12'd1, 32'h0, 16'd1,
                    32'h40, 12'd64, 32'h0, 12'd0, 32'h0, 12'd0, 32'h0, 12'd0,
                    32'h40, 12'd64);
        tbl[5] = mk(32'h0, 12'd4095, 12'd1, 32'h0, 16'd64,
                    32'h0, 12'd64, 32'h100, 12'd64, 32'h200, 12'd64, 32'h300, 12'd64,
                    32'h3F00, 12'd63);

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_kick", 32'(kick), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        chk("reset_addr", read_addr, 32'd0);
        chk("reset_num", 32'(read_num), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 32'(active), 32'd0);

        // Table-driven frames with auto busy response and fifo gate open
        auto_busy = 1'b1;
        fifo_available = 32'd0;
        fifo_threshold = 32'd1600;
        for (int r = 0; r < 6; r++) run_row(r, tbl[r]);

        // busy held high before the first request
        auto_busy = 1'b0;
        busy_man = 1'b1;
        n0 = req_n; d0 = done_cnt; s0 = stab_err;
        start_frame(32'h3000, 12'd128, 12'd1, 32'h0);
        hk = 0;
        repeat (10) begin @(negedge clk); if (kick) hk++; end
        chk("busyhold_no_kick", 32'(hk), 32'd0);
        step();
        busy_man = 1'b0;
        wait_kick(5, "busyhold_kick");
        hk = 0;
        repeat (5) begin
            @(negedge clk);
            if (kick && (read_addr == 32'h3000)) hk++;
        end
        chk("busyhold_kick_held", 32'(hk), 32'd5);
        step();
        busy_man = 1'b1;
        step();
        busy_man = 1'b0;
        auto_busy = 1'b1;
        wait_done(d0, 200, "busyhold_done");
        chk("busyhold_count", 32'(req_n - n0), 32'd2);
        chk("busyhold_req1_addr", mon_addr[n0 + 1], 32'h3100);
        chk("busyhold_stable", 32'(stab_err - s0), 32'd0);

        // fifo gating of the next line
        fifo_available = 32'd2000;
        n0 = req_n; d0 = done_cnt;
        start_frame(32'h8000, 12'd64, 12'd2, 32'h100);
        for (int c = 1; c < 50; c++) step();
        step();
        fifo_available = 32'd1000;
        @(negedge clk);
        chk("fifo_gate_held", 32'(req_n - n0), 32'd1);
        chk("fifo_gate_active", 32'(active), 32'd1);
        wait_done(d0, 200, "fifo_gate_done");
        chk("fifo_gate_count", 32'(req_n - n0), 32'd2);
        chk("fifo_gate_line1_addr", mon_addr[n0 + 1], 32'h8100);
        fifo_available = 32'd0;

        // Abort during ISSUE_WAIT of the first burst
        auto_busy = 1'b0;
        busy_man = 1'b0;
        n0 = req_n; d0 = done_cnt;
        start_frame(32'hA000, 12'd100, 12'd2, 32'd512);
        wait_kick(10, "abort_kick");
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        hk = 0;
        repeat (3) begin @(negedge clk); if (kick) hk++; end
        chk("abort_kick_held", 32'(hk), 32'd3);
        step();
        busy_man = 1'b1;
        step();
        busy_man = 1'b0;
        @(negedge clk);
        chk("abort_kick_low", 32'(kick), 32'd0);
        chk("abort_idle", 32'(active), 32'd0);
        chk("abort_done_pulse", 32'(frame_done), 32'd1);
        repeat (10) @(negedge clk);
        chk("abort_one_request", 32'(req_n - n0), 32'd1);
        chk("abort_done_once", 32'(done_cnt - d0), 32'd1);

        // Zero-size starts
        auto_busy = 1'b1;
        n0 = req_n; d0 = done_cnt;
        step();
        frame_base = 32'h4000; x_size = 12'd10; y_size = 12'd0; start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("zero_y_done_pulse", 32'(frame_done), 32'd1);
        chk("zero_y_inactive", 32'(active), 32'd0);
        @(negedge clk);
        chk("zero_y_done_width", 32'(frame_done), 32'd0);
        step();
        x_size = 12'd0; y_size = 12'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("zero_size_no_kick", 32'(req_n - n0), 32'd0);
        chk("zero_size_done_count", 32'(done_cnt - d0), 32'd2);

        // start during an active frame is ignored
        n0 = req_n; d0 = done_cnt;
        start_frame(32'h5000, 12'd64, 12'd2, 32'h100);
        wait_kick(10, "restart_kick");
        step();
        frame_base = 32'h9000; x_size = 12'd8; y_size = 12'd1; line_stride = 32'h0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(d0, 200, "restart_done");
        chk("restart_count", 32'(req_n - n0), 32'd2);
        chk("restart_req0_addr", mon_addr[n0], 32'h5000);
        chk("restart_req1_addr", mon_addr[n0 + 1], 32'h5100);
        chk("restart_req1_num", 32'(mon_num[n0 + 1]), 32'd64);

        // Reset asserted while kick is high
        auto_busy = 1'b0;
        busy_man = 1'b0;
        start_frame(32'h6000, 12'd64, 12'd1, 32'h0);
        wait_kick(10, "rst_kick");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_kick", 32'(kick), 32'd0);
        chk("rst_mid_addr", read_addr, 32'd0);
        chk("rst_mid_num", 32'(read_num), 32'd0);
        chk("rst_mid_active", 32'(active), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        auto_busy = 1'b1;
        n0 = req_n; d0 = done_cnt;
        start_frame(32'h7000, 12'd64, 12'd1, 32'h0);
        wait_done(d0, 200, "post_rst_done");
        chk("post_rst_count", 32'(req_n - n0), 32'd1);
        chk("post_rst_first_addr", mon_addr[n0], 32'h7000);
        chk("post_rst_first_num", 32'(mon_num[n0]), 32'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_read_addr_gen.md
FRAME_READ_ADDR_GEN -- requirements
Module: frame_read_addr_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  32  address width
  BPP  4  bytes per pixel, power of two
  BURST_PIX  64  max pixels per request
  DIM_W  12  width of x_size/y_size and counters
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous assert, active-low
  start  in  1  frame request pulse; honoured only in IDLE
  abort  in  1  stop frame after current handshake
  frame_base  in  ADDR_W  frame byte base address, latched on start
  x_size  in  DIM_W  pixels per line, latched on start
  y_size  in  DIM_W  lines per frame, latched on start
  line_stride  in  ADDR_W  bytes between line starts, latched on start
  fifo_available  in  32  downstream fill level
  fifo_threshold  in  32  line-prefetch gate, sampled live
  busy  in  1  read engine busy
  kick  out  1  request valid
  read_addr  out  ADDR_W  request byte address
  read_num  out  DIM_W  pixels in request, 1..BURST_PIX
  active  out  1  high when state is not IDLE
  frame_done  out  1  one-cycle pulse at frame end or abort completion
REQ-003 All outputs SHALL be registered or decoded only from state; no input-to-output combinational path.

Function
REQ-004 States SHALL be IDLE, ISSUE_IDLE, ISSUE, ISSUE_WAIT, NEXT_LINE.
REQ-005 IDLE: start=1 with x_size!=0 and y_size!=0 SHALL latch frame_base/x_size/y_size/line_stride, clear x_cnt/y_cnt, go to ISSUE_IDLE.
REQ-006 IDLE: start=1 with x_size==0 or y_size==0 SHALL pulse frame_done next cycle, stay IDLE, no kick.
REQ-007 ISSUE_IDLE: busy=0 SHALL go to ISSUE; same edge SHALL load read_addr = base + y_cnt*stride + x_cnt*BPP (mod 2^ADDR_W) and read_num = min(BURST_PIX, x_size - x_cnt).
REQ-008 ISSUE SHALL last exactly one cycle, add read_num to x_cnt, go to ISSUE_WAIT.
REQ-009 ISSUE_WAIT: busy=1 SHALL go to NEXT_LINE if x_cnt==x_size, else ISSUE_IDLE; busy=0 SHALL hold.
REQ-010 kick SHALL be 1 exactly in ISSUE and ISSUE_WAIT; read_addr/read_num SHALL be stable while kick=1.
REQ-011 Entering NEXT_LINE SHALL clear x_cnt and increment y_cnt.
REQ-012 NEXT_LINE: y_cnt==y_size SHALL pulse frame_done and go IDLE; else fifo_available < fifo_threshold SHALL go ISSUE_IDLE; else hold.
REQ-013 Last burst of a line SHALL be partial when x_size is not a multiple of BURST_PIX; no burst crosses a line end.
REQ-014 abort in ISSUE_IDLE or NEXT_LINE SHALL go IDLE next cycle with frame_done pulse; no further kick.
REQ-015 abort in ISSUE or ISSUE_WAIT SHALL be recorded; on busy=1 in ISSUE_WAIT go IDLE with frame_done pulse.
REQ-016 abort has priority over start, fifo gating and line completion; start outside IDLE SHALL be ignored; changes to latched inputs mid-frame SHALL have no effect.
REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_W without error indication.
REQ-018 Counters SHALL be DIM_W+1 bits so x_size/y_size at 2^DIM_W-1 terminate correctly.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, kick=0, active=0, frame_done=0, read_addr=0, read_num=0, counters 0, abort flag 0, including mid-handshake.
REQ-020 After rst_n release the block SHALL wait in IDLE for start.

Verification
REQ-021 Bench SHALL cover:
  base=0x1000, x=100, y=2, stride=512, BURST_PIX=64, threshold=1600, fifo=0, busy rises 2 cycles after kick -> requests (0x1000,64),(0x1100,36),(0x1200,64),(0x1300,36), one frame_done.
  x=128, y=1, busy held 1 for 10 cycles -> no kick until busy=0; kick held until busy=1; read_addr stable throughout.
  fifo_available=2000 after line 0, drops to 1000 at cycle 50 -> no line-1 kick before cycle 51.
  abort during ISSUE_WAIT of first burst -> kick held until busy=1, then IDLE, frame_done once, no second request.
  start with y_size=0 -> frame_done one cycle later, kick never asserted; start during active frame ignored.
  rst_n low while kick=1 -> kick=0 same cycle, read_addr=0; new start after release yields first address = frame_base.
